// File: rtl/neuron_accumulator.sv
// Neuron accumulator: sums a stream of signed 16-bit product terms onto a bias
// with per-add saturation, then presents an optionally ReLU'd result.
module neuron_accumulator #(
    parameter int RELU_EN = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] bias,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        out_sat
);

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        OUT
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [15:0] acc;
    logic        sat_flag;
    logic [15:0] addend;
    logic [16:0] sum;
    logic [15:0] add_result;
    logic        add_clamped;
    logic        beat;

    assign in_ready  = (state != OUT);
    assign out_valid = (state == OUT);
    assign beat      = in_valid && in_ready;
    assign out_sat   = sat_flag;
    assign out_data  = ((RELU_EN != 0) && acc[15]) ? 16'h0000 : acc;

    // The first beat of a vector adds onto the bias, later beats onto acc.
    always_comb begin
        addend      = (state == IDLE) ? bias : acc;
        sum         = {addend[15], addend} + {in_data[15], in_data};
        add_result  = sum[15:0];
        add_clamped = 1'b0;
        case (sum[16:15])
            2'b01: begin
                add_result  = 16'h7FFF;
                add_clamped = 1'b1;
            end
            2'b10: begin
                add_result  = 16'h8000;
                add_clamped = 1'b1;
            end
            default: begin
                add_result  = sum[15:0];
                add_clamped = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (beat) state_next = in_last ? OUT : ACC;
            ACC:  if (beat && in_last) state_next = OUT;
            OUT:  if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            acc      <= 16'h0000;
            sat_flag <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (beat) begin
                        acc      <= add_result;
                        sat_flag <= add_clamped;
                    end
                end
                ACC: begin
                    if (beat) begin
                        acc      <= add_result;
                        sat_flag <= sat_flag | add_clamped;
                    end
                end
                OUT: begin
                    // Clearing here leaves IDLE with a zero result visible.
                    if (out_ready) begin
                        acc      <= 16'h0000;
                        sat_flag <= 1'b0;
                    end
                end
                default: begin
                    acc      <= 16'h0000;
                    sat_flag <= 1'b0;
                end
            endcase
        end
    end

endmodule
